// File: rtl/control_unit_fsm_pkg.sv
// rtl/control_unit_fsm_pkg.sv - shared constants and types for the cs147 control unit
package cs147_ctrl_pkg;

  localparam int CTRL_W = 32;
  localparam int ST_W   = 3;

  localparam int PC_LOAD   = 0;
  localparam int PC_SEL1   = 1;
  localparam int PC_SEL2   = 2;
  localparam int PC_SEL3   = 3;
  localparam int IR_LOAD   = 4;
  localparam int R1_SEL    = 7;
  localparam int REG_READ  = 8;
  localparam int REG_WRITE = 9;
  localparam int WA_SEL1   = 10;
  localparam int WA_SEL2   = 11;
  localparam int WA_SEL3   = 12;
  localparam int WD_SEL1   = 13;
  localparam int WD_SEL2   = 14;
  localparam int WD_SEL3   = 15;
  localparam int SP_LOAD   = 16;
  localparam int OP1_SEL   = 17;
  localparam int OP2_SEL1  = 18;
  localparam int OP2_SEL2  = 19;
  localparam int OP2_SEL3  = 20;
  localparam int OP2_SEL4  = 21;
  localparam int OPRN_LO   = 22;
  localparam int OPRN_HI   = 25;
  localparam int MA_SEL1   = 26;
  localparam int MA_SEL2   = 27;
  localparam int MD_SEL    = 28;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2c;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_MUL = 4'd3, ALU_SHR = 4'd4,
    ALU_SHL  = 4'd5, ALU_AND = 4'd6, ALU_OR  = 4'd7, ALU_NOR = 4'd8, ALU_SLT = 4'd9
  } aluOprn_t;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } ctrlState_t;

endpackage

// File: rtl/control_unit_fsm_if.sv
// rtl/control_unit_fsm_if.sv - datapath <-> control unit signal bundle
interface control_unit_fsm_if;
  import cs147_ctrl_pkg::*;

  logic [31:0]     INSTRUCTION;
  logic            ZERO;
  logic [CTRL_W-1:0] CTRL;
  logic            READ;
  logic            WRITE;
  logic [ST_W-1:0] STATE;

  modport master (input INSTRUCTION, ZERO, output CTRL, READ, WRITE, STATE);
  modport slave  (output INSTRUCTION, ZERO, input CTRL, READ, WRITE, STATE);
endinterface

// File: rtl/control_unit_fsm_decode.sv
// rtl/control_unit_fsm_decode.sv - combinational control word decode from state and instruction
module control_decode
  import cs147_ctrl_pkg::*;
(
  input  ctrlState_t        state,
  input  logic [31:0]       instruction,
  input  logic              zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic              read,
  output logic              write
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unusedFields;

  assign opcode       = instruction[31:26];
  assign funct        = instruction[5:0];
  assign unusedFields = ^instruction[25:6];

  aluOprn_t oprn;
  logic op2R2, op2Shamt, op2One, op2Sext, op1Sp, noR1;
  logic memRead, memWrite, memSp, regWr, waRt, waR31;
  logic wdMem, wdLui, wdPc, spLd, pcR1, pcJump, pcBranch;
  logic [CTRL_W-1:0] aluHold;

  always_comb begin
    oprn = ALU_NONE;
    op2R2 = 1'b0; op2Shamt = 1'b0; op2One = 1'b0; op2Sext = 1'b0; op1Sp = 1'b0; noR1 = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; memSp = 1'b0; regWr = 1'b0; waRt = 1'b0; waR31 = 1'b0;
    wdMem = 1'b0; wdLui = 1'b0; wdPc = 1'b0; spLd = 1'b0;
    pcR1 = 1'b0; pcJump = 1'b0; pcBranch = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin oprn = ALU_ADD; op2R2 = 1'b1; regWr = 1'b1; end
          FN_SUB: begin oprn = ALU_SUB; op2R2 = 1'b1; regWr = 1'b1; end
          FN_MUL: begin oprn = ALU_MUL; op2R2 = 1'b1; regWr = 1'b1; end
          FN_AND: begin oprn = ALU_AND; op2R2 = 1'b1; regWr = 1'b1; end
          FN_OR:  begin oprn = ALU_OR;  op2R2 = 1'b1; regWr = 1'b1; end
          FN_NOR: begin oprn = ALU_NOR; op2R2 = 1'b1; regWr = 1'b1; end
          FN_SLT: begin oprn = ALU_SLT; op2R2 = 1'b1; regWr = 1'b1; end
          FN_SLL: begin oprn = ALU_SHL; op2Shamt = 1'b1; regWr = 1'b1; end
          FN_SRL: begin oprn = ALU_SHR; op2Shamt = 1'b1; regWr = 1'b1; end
          FN_JR:  pcR1 = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin oprn = ALU_ADD; op2Sext = 1'b1; regWr = 1'b1; waRt = 1'b1; end
      OP_MULI: begin oprn = ALU_MUL; op2Sext = 1'b1; regWr = 1'b1; waRt = 1'b1; end
      OP_SLTI: begin oprn = ALU_SLT; op2Sext = 1'b1; regWr = 1'b1; waRt = 1'b1; end
      OP_ANDI: begin oprn = ALU_AND; regWr = 1'b1; waRt = 1'b1; end
      OP_ORI:  begin oprn = ALU_OR;  regWr = 1'b1; waRt = 1'b1; end
      OP_LUI:  begin regWr = 1'b1; waRt = 1'b1; wdLui = 1'b1; end
      OP_LW: begin
        oprn = ALU_ADD; op2Sext = 1'b1; memRead = 1'b1;
        regWr = 1'b1; waRt = 1'b1; wdMem = 1'b1;
      end
      OP_SW:   begin oprn = ALU_ADD; op2Sext = 1'b1; memWrite = 1'b1; end
      OP_BEQ:  begin oprn = ALU_SUB; op2R2 = 1'b1; pcBranch = zero; end
      OP_BNE:  begin oprn = ALU_SUB; op2R2 = 1'b1; pcBranch = ~zero; end
      OP_JMP:  pcJump = 1'b1;
      OP_JAL:  begin pcJump = 1'b1; regWr = 1'b1; waR31 = 1'b1; wdPc = 1'b1; end
      // push stores R0 at SP, then decrements SP; R1 is pointed at R0 for the store data.
      OP_PUSH: begin
        oprn = ALU_SUB; op1Sp = 1'b1; op2One = 1'b1; noR1 = 1'b1;
        memWrite = 1'b1; memSp = 1'b1; spLd = 1'b1;
      end
      OP_POP: begin
        oprn = ALU_ADD; op1Sp = 1'b1; op2One = 1'b1; memRead = 1'b1;
        regWr = 1'b1; wdMem = 1'b1; spLd = 1'b1;
      end
      default: ;
    endcase
  end

  // Register read and ALU operand selects stay put from EXECUTE on so the ALU result is stable.
  always_comb begin
    aluHold = '0;
    aluHold[REG_READ] = 1'b1;
    aluHold[R1_SEL]   = ~noR1;
    aluHold[OP1_SEL]  = op1Sp;
    aluHold[OP2_SEL4] = op2R2;
    aluHold[OP2_SEL3] = op2Shamt | op2One;
    aluHold[OP2_SEL1] = op2Shamt;
    aluHold[OP2_SEL2] = op2Sext;
    aluHold[OPRN_HI:OPRN_LO] = oprn;
  end

  always_comb begin
    ctrl  = '0;
    read  = 1'b0;
    write = 1'b0;
    case (state)
      ST_FETCH: begin
        ctrl[MA_SEL2] = 1'b1;
        ctrl[IR_LOAD] = 1'b1;
        read          = 1'b1;
      end
      ST_DECODE: begin
        ctrl[REG_READ] = 1'b1;
        ctrl[R1_SEL]   = ~noR1;
      end
      ST_EXECUTE: ctrl = aluHold;
      ST_MEMORY: begin
        ctrl          = aluHold;
        ctrl[MA_SEL1] = memSp;
        ctrl[MD_SEL]  = memSp;
        read          = memRead;
        write         = memWrite;
      end
      ST_WRITEBACK: begin
        ctrl            = aluHold;
        ctrl[PC_LOAD]   = 1'b1;
        ctrl[PC_SEL1]   = ~pcR1;
        ctrl[PC_SEL2]   = pcBranch;
        ctrl[PC_SEL3]   = ~pcJump;
        ctrl[REG_WRITE] = regWr;
        ctrl[WA_SEL1]   = waRt;
        ctrl[WA_SEL3]   = waRt;
        ctrl[WA_SEL2]   = waR31;
        ctrl[WD_SEL1]   = wdMem;
        ctrl[WD_SEL2]   = wdLui;
        ctrl[WD_SEL3]   = ~wdPc;
        ctrl[SP_LOAD]   = spLd;
        read            = wdMem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// rtl/control_unit_fsm.sv - five-state multi-cycle control unit for the cs147sec05 processor
module control_unit_fsm
  import cs147_ctrl_pkg::*;
(
  input logic                CLK,
  input logic                RST,
  control_unit_fsm_if.master bus
);

  ctrlState_t state;
  ctrlState_t nextState;
  logic [CTRL_W-1:0] ctrlComb;
  logic readComb;
  logic writeComb;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_FETCH;
    else     state <= nextState;
  end

  always_comb begin
    nextState = ST_FETCH;
    case (state)
      ST_FETCH:     nextState = ST_DECODE;
      ST_DECODE:    nextState = ST_EXECUTE;
      ST_EXECUTE:   nextState = ST_MEMORY;
      ST_MEMORY:    nextState = ST_WRITEBACK;
      ST_WRITEBACK: nextState = ST_FETCH;
      default:      nextState = ST_FETCH;
    endcase
  end

  control_decode u_decode (
    .state       (state),
    .instruction (bus.INSTRUCTION),
    .zero        (bus.ZERO),
    .ctrl        (ctrlComb),
    .read        (readComb),
    .write       (writeComb)
  );

  // State already sits at FETCH under reset; gating keeps FETCH strobes off until release.
  assign bus.CTRL  = RST ? '0 : ctrlComb;
  assign bus.READ  = RST ? 1'b0 : readComb;
  assign bus.WRITE = RST ? 1'b0 : writeComb;
  assign bus.STATE = state;

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb/tb_control_unit_fsm.sv - randomized self-checking bench for control_unit_fsm
module tb_control_unit_fsm;

  typedef struct packed {
    logic [31:0] ctrl;
    logic        rd;
    logic        wr;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  control_unit_fsm_if bus ();

  control_unit_fsm dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural view: classify the instruction, then place bits by the datapath's bit map.
  function automatic exp_t model(int st, logic [31:0] ins, logic z);
    exp_t e;
    logic [5:0] op, fn;
    logic [31:0] hold;
    int alu, o2, tgt, data, pc;
    bit sp, noR1, mRd, mWr, mPush, wr, spW;
    op = ins[31:26]; fn = ins[5:0];
    alu = 0; o2 = 0; tgt = 0; data = 0; pc = 0;
    sp = 0; noR1 = 0; mRd = 0; mWr = 0; mPush = 0; wr = 0; spW = 0;
    case (op)
      6'h00: case (fn)
        6'h20: begin alu = 1; o2 = 1; wr = 1; end
        6'h22: begin alu = 2; o2 = 1; wr = 1; end
        6'h2c: begin alu = 3; o2 = 1; wr = 1; end
        6'h24: begin alu = 6; o2 = 1; wr = 1; end
        6'h25: begin alu = 7; o2 = 1; wr = 1; end
        6'h27: begin alu = 8; o2 = 1; wr = 1; end
        6'h2a: begin alu = 9; o2 = 1; wr = 1; end
        6'h01: begin alu = 5; o2 = 2; wr = 1; end
        6'h02: begin alu = 4; o2 = 2; wr = 1; end
        6'h08: pc = 1;
        default: ;
      endcase
      6'h08: begin alu = 1; o2 = 4; wr = 1; tgt = 1; end
      6'h1d: begin alu = 3; o2 = 4; wr = 1; tgt = 1; end
      6'h0a: begin alu = 9; o2 = 4; wr = 1; tgt = 1; end
      6'h0c: begin alu = 6; o2 = 5; wr = 1; tgt = 1; end
      6'h0d: begin alu = 7; o2 = 5; wr = 1; tgt = 1; end
      6'h0f: begin wr = 1; tgt = 1; data = 2; end
      6'h23: begin alu = 1; o2 = 4; mRd = 1; wr = 1; tgt = 1; data = 1; end
      6'h2b: begin alu = 1; o2 = 4; mWr = 1; end
      6'h04: begin alu = 2; o2 = 1; pc = z ? 3 : 0; end
      6'h05: begin alu = 2; o2 = 1; pc = z ? 0 : 3; end
      6'h02: pc = 2;
      6'h03: begin pc = 2; wr = 1; tgt = 2; data = 3; end
      6'h1b: begin alu = 2; sp = 1; o2 = 3; noR1 = 1; mWr = 1; mPush = 1; spW = 1; end
      6'h1c: begin alu = 1; sp = 1; o2 = 3; mRd = 1; wr = 1; data = 1; spW = 1; end
      default: ;
    endcase
    hold = 32'h0;
    hold[8] = 1'b1;
    hold[7] = !noR1;
    hold[17] = sp;
    if (o2 == 1) hold[21] = 1'b1;
    if (o2 == 2) begin hold[20] = 1'b1; hold[18] = 1'b1; end
    if (o2 == 3) hold[20] = 1'b1;
    if (o2 == 4) hold[19] = 1'b1;
    hold = hold | (32'(alu) << 22);
    e = '0;
    case (st)
      0: begin e.ctrl = 32'h0800_0010; e.rd = 1'b1; end
      1: begin e.ctrl[8] = 1'b1; e.ctrl[7] = !noR1; end
      2: e.ctrl = hold;
      3: begin
        e.ctrl = hold; e.rd = mRd; e.wr = mWr;
        if (mPush) begin e.ctrl[26] = 1'b1; e.ctrl[28] = 1'b1; end
      end
      default: begin
        e.ctrl = hold; e.ctrl[0] = 1'b1;
        case (pc)
          0: begin e.ctrl[1] = 1'b1; e.ctrl[3] = 1'b1; end
          1: e.ctrl[3] = 1'b1;
          2: e.ctrl[1] = 1'b1;
          default: begin e.ctrl[1] = 1'b1; e.ctrl[2] = 1'b1; e.ctrl[3] = 1'b1; end
        endcase
        e.ctrl[9] = wr;
        if (tgt == 1) begin e.ctrl[10] = 1'b1; e.ctrl[12] = 1'b1; end
        if (tgt == 2) e.ctrl[11] = 1'b1;
        if (data == 1) begin e.ctrl[13] = 1'b1; e.rd = 1'b1; end
        if (data == 2) e.ctrl[14] = 1'b1;
        if (data != 3) e.ctrl[15] = 1'b1;
        e.ctrl[16] = spW;
      end
    endcase
    return e;
  endfunction

  // Walks nStates of one instruction, checking at each negedge; zmode<0 randomizes ZERO.
  task automatic runInstr(input string tag, input logic [31:0] ins, input int zmode, input int nStates);
    exp_t e;
    bus.INSTRUCTION = ins;
    for (int s = 0; s < nStates; s++) begin
      bus.ZERO = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge CLK);
      e = model(s, ins, bus.ZERO);
      checkVal($sformatf("%s st%0d state", tag, s), 32'(bus.STATE), 32'(s));
      checkVal($sformatf("%s st%0d ctrl", tag, s), bus.CTRL, e.ctrl);
      checkVal($sformatf("%s st%0d read", tag, s), 32'(bus.READ), 32'(e.rd));
      checkVal($sformatf("%s st%0d write", tag, s), 32'(bus.WRITE), 32'(e.wr));
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, " state"}, 32'(bus.STATE), 32'd0);
    checkVal({tag, " ctrl"}, bus.CTRL, 32'd0);
    checkVal({tag, " read"}, 32'(bus.READ), 32'd0);
    checkVal({tag, " write"}, 32'(bus.WRITE), 32'd0);
  endtask

  logic [5:0] opPool [19] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h04,
                              6'h05, 6'h23, 6'h2b, 6'h02, 6'h03, 6'h1b, 6'h1c, 6'h3f, 6'h11};
  logic [5:0] fnPool [11] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02, 6'h08, 6'h3e};

  initial begin
    logic [31:0] ins;
    RST = 1'b1;
    bus.INSTRUCTION = 32'h0;
    bus.ZERO = 1'b0;
    #1;
    checkReset("reset");
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    runInstr("add", 32'h0043_0820, -1, 3);
    #2 RST = 1'b1;
    #1 checkReset("rst mid exec");
    @(posedge CLK);
    #1 checkReset("rst held");
    @(posedge CLK);
    #2 RST = 1'b0;

    runInstr("add", 32'h0043_0820, -1, 5);
    runInstr("beq z1", 32'h1022_0003, 1, 5);
    runInstr("beq z0", 32'h1022_0003, 0, 5);
    runInstr("bne z0", 32'h1422_0003, 0, 5);
    runInstr("lw", 32'h8C22_FFFC, -1, 5);
    runInstr("push", 32'h6C00_0000, -1, 5);
    runInstr("pop", 32'h7000_0000, -1, 5);
    runInstr("jal", 32'h0C00_0010, -1, 5);
    runInstr("illegal", 32'hFC00_0000, -1, 5);

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[31:26] = opPool[$urandom_range(0, 18)];
      if (ins[31:26] == 6'h00) ins[5:0] = fnPool[$urandom_range(0, 10)];
      runInstr($sformatf("rand%0d op%02h", n, ins[31:26]), ins, -1, 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
